// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: shared register addresses, mode encodings, FSM states and bounce directions.
`default_nettype none

package led_sequencer_pkg;

    localparam logic [1:0] ADDR_PAT    = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_CUR    = 2'd3;

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/led_prescaler.sv
// led_prescaler: step-rate counter; tick is high for the single cycle in which cnt reaches period-1.
`default_nettype none

module led_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt;

    // A clear in the same cycle suppresses the tick so a bus write always wins.
    assign tick = en && !clr && (cnt == (period - 32'd1));

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= 32'd0;
        end else if (tick) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// led_sequencer: sole writer of the LED output register, arbitrating CPU writes and the pattern engine.
`default_nettype none

module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter logic [31:0] CLK_DIV = 32'd25000000,
    parameter int          LED_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_we,
    input  logic [1:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic [LED_W-1:0] led_din,
    output logic             led_we
);

    state_t           state, state_n;
    logic [LED_W-1:0] pat, pat_n;
    logic [1:0]       mode, mode_n;
    logic [31:0]      period, period_n;
    logic [LED_W-1:0] cur, cur_n;
    logic             dir, dir_n;
    logic             phase, phase_n;
    logic [LED_W-1:0] din_n;
    logic             we_n;
    logic             tick;
    logic             bus_wr;

    // Writes to the read-only CUR address are ignored and do not disturb the step counter.
    assign bus_wr = bus_we && (bus_addr != ADDR_CUR);

    led_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus_wr),
        .en     (state == ST_RUN),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_n  = state;
        pat_n    = pat;
        mode_n   = mode;
        period_n = period;
        cur_n    = cur;
        dir_n    = dir;
        phase_n  = phase;
        din_n    = led_din;
        we_n     = 1'b0;

        case (state)
            ST_INIT: begin
                state_n = ST_MANUAL;
                din_n   = '0;
                we_n    = 1'b1;
            end
            ST_RUN: begin
                if (tick) begin
                    we_n = 1'b1;
                    case (mode)
                        MODE_BLINK: begin
                            phase_n = ~phase;
                            din_n   = phase ? cur : '0;
                        end
                        MODE_ROTATE: begin
                            cur_n = {cur[LED_W-2:0], cur[LED_W-1]};
                            din_n = {cur[LED_W-2:0], cur[LED_W-1]};
                        end
                        MODE_BOUNCE: begin
                            if (dir == DIR_LEFT) begin
                                if (cur[LED_W-1]) begin
                                    dir_n = DIR_RIGHT;
                                    cur_n = cur >> 1;
                                end else begin
                                    cur_n = cur << 1;
                                end
                            end else begin
                                if (cur[0]) begin
                                    dir_n = DIR_LEFT;
                                    cur_n = cur << 1;
                                end else begin
                                    cur_n = cur >> 1;
                                end
                            end
                            din_n = cur_n;
                        end
                        default: we_n = 1'b0;
                    endcase
                end
            end
            default: ;
        endcase

        // The prescaler has already dropped any coincident tick, so the bus simply overrides.
        if (bus_wr) begin
            case (bus_addr)
                ADDR_PAT: begin
                    pat_n   = bus_wdata[LED_W-1:0];
                    cur_n   = bus_wdata[LED_W-1:0];
                    phase_n = 1'b0;
                    dir_n   = DIR_LEFT;
                    din_n   = bus_wdata[LED_W-1:0];
                    we_n    = 1'b1;
                end
                ADDR_MODE: begin
                    mode_n  = bus_wdata[1:0];
                    cur_n   = pat;
                    phase_n = 1'b0;
                    dir_n   = DIR_LEFT;
                    state_n = (bus_wdata[1:0] == MODE_MANUAL) ? ST_MANUAL : ST_RUN;
                    din_n   = pat;
                    we_n    = 1'b1;
                end
                default: begin
                    period_n = (bus_wdata == 32'd0) ? 32'd1 : bus_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            pat     <= '0;
            mode    <= MODE_MANUAL;
            period  <= CLK_DIV;
            cur     <= '0;
            dir     <= DIR_LEFT;
            phase   <= 1'b0;
            led_din <= '0;
            led_we  <= 1'b0;
        end else begin
            state   <= state_n;
            pat     <= pat_n;
            mode    <= mode_n;
            period  <= period_n;
            cur     <= cur_n;
            dir     <= dir_n;
            phase   <= phase_n;
            led_din <= din_n;
            led_we  <= we_n;
        end
    end

    always_comb begin
        case (bus_addr)
            ADDR_PAT:    bus_rdata = {{(32-LED_W){1'b0}}, pat};
            ADDR_MODE:   bus_rdata = {30'd0, mode};
            ADDR_PERIOD: bus_rdata = period;
            default:     bus_rdata = {{(32-LED_W){1'b0}}, cur};
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard of expected LED strobes (cycle + value) plus table-driven pattern runs.
`default_nettype none

module tb_led_sequencer;
    import led_sequencer_pkg::*;

    localparam logic [31:0] TB_DIV = 32'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [15:0] led_din;
    logic        led_we;

    led_sequencer #(.CLK_DIV(TB_DIV), .LED_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .led_din   (led_din),
        .led_we    (led_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] din;
    } strobe_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] period;
        logic [15:0] pat;
        int          nsteps;
        logic [15:0] last_din;
        logic [15:0] last_cur;
    } vec_t;

    strobe_t sb[$];
    int checks = 0;
    int errors = 0;

    // Every strobe must match the head of the scoreboard in both cycle and value.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_strobe cycle %0d expected din %h, led_we stayed low", sb[0].cyc, sb[0].din);
                void'(sb.pop_front());
            end
            if (led_we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cycle %0d din %h, none expected", cyc, led_din);
                end else begin
                    strobe_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.din !== led_din) begin
                        errors++;
                        $display("FAIL strobe got cycle %0d din %h, want cycle %0d din %h",
                                 cyc, led_din, e.cyc, e.din);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(name, bus_rdata, exp);
    endtask

    task automatic push(input int c, input logic [15:0] d);
        strobe_t s;
        s.cyc = c;
        s.din = d;
        sb.push_back(s);
    endtask

    // Called #1 after a posedge; the write is captured by the next edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                             input bit strobe, input logic [15:0] exp);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
        if (strobe) push(cyc, exp);
    endtask

    task automatic model_step(input logic [1:0] m, inout logic [15:0] c, inout logic d,
                              inout logic ph, output logic [15:0] out);
        out = c;
        case (m)
            MODE_BLINK: begin
                ph  = ~ph;
                out = ph ? 16'h0000 : c;
            end
            MODE_ROTATE: begin
                c   = {c[14:0], c[15]};
                out = c;
            end
            default: begin
                if (c == 16'h0000) begin
                    out = c;
                end else if (d == DIR_LEFT) begin
                    if (c == 16'h8000 || c[15]) begin d = DIR_RIGHT; c = c >> 1; end
                    else c = c << 1;
                end else begin
                    if (c[0]) begin d = DIR_LEFT; c = c << 1; end
                    else c = c >> 1;
                end
                out = c;
            end
        endcase
    endtask

    task automatic run_vector(input vec_t v);
        int          k;
        int          p;
        logic [15:0] mc;
        logic        md;
        logic        mph;
        logic [15:0] mo;
        p = int'(v.period);
        bus_write(ADDR_PERIOD, v.period, 1'b0, 16'h0);
        bus_write(ADDR_PAT, {16'h0, v.pat}, 1'b1, v.pat);
        bus_write(ADDR_MODE, {30'd0, v.mode}, 1'b1, v.pat);
        k   = cyc;
        mc  = v.pat;
        md  = DIR_LEFT;
        mph = 1'b0;
        for (int i = 1; i <= v.nsteps; i++) begin
            model_step(v.mode, mc, md, mph, mo);
            push(k + i * p, (i == v.nsteps) ? v.last_din : mo);
        end
        repeat (v.nsteps * p) @(posedge clk);
        #1;
        rd("cur_after_run", ADDR_CUR, {16'h0, v.last_cur});
        rd("mode_readback", ADDR_MODE, {30'd0, v.mode});
        bus_write(ADDR_MODE, 32'd0, 1'b1, v.pat);
    endtask

    vec_t vecs[6];

    initial begin
        int k;
        vecs[0] = '{MODE_ROTATE, 32'd4, 16'h0001, 16, 16'h0001, 16'h0001};
        vecs[1] = '{MODE_BOUNCE, 32'd2, 16'h4000, 17, 16'h0002, 16'h0002};
        vecs[2] = '{MODE_BLINK,  32'd3, 16'h00FF, 4,  16'h00FF, 16'h00FF};
        vecs[3] = '{MODE_ROTATE, 32'd1, 16'h8001, 3,  16'h000C, 16'h000C};
        vecs[4] = '{MODE_BOUNCE, 32'd1, 16'h0000, 3,  16'h0000, 16'h0000};
        vecs[5] = '{MODE_BLINK,  32'd2, 16'h1234, 3,  16'h0000, 16'h1234};

        rst       = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led_we", {31'd0, led_we}, 32'd0);
        chk("reset_led_din", {16'd0, led_din}, 32'd0);
        rd("reset_pat", ADDR_PAT, 32'd0);
        rd("reset_mode", ADDR_MODE, 32'd0);
        rd("reset_period", ADDR_PERIOD, TB_DIV);
        rd("reset_cur", ADDR_CUR, 32'd0);

        rst = 1'b0;
        push(cyc + 1, 16'h0000);
        repeat (101) @(posedge clk);
        #1;
        chk("manual_idle_queue", sb.size(), 32'd0);

        bus_write(ADDR_PAT, 32'h0000A5A5, 1'b1, 16'hA5A5);
        rd("pat_readback", ADDR_PAT, 32'h0000A5A5);
        bus_write(ADDR_CUR, 32'h0000FFFF, 1'b0, 16'h0);
        rd("cur_write_ignored", ADDR_CUR, 32'h0000A5A5);

        foreach (vecs[i]) run_vector(vecs[i]);

        // PAT write landing exactly on a BLINK tick: one strobe, count restarts.
        bus_write(ADDR_PERIOD, 32'd3, 1'b0, 16'h0);
        bus_write(ADDR_PAT, 32'h000000FF, 1'b1, 16'h00FF);
        bus_write(ADDR_MODE, {30'd0, MODE_BLINK}, 1'b1, 16'h00FF);
        k = cyc;
        push(k + 3, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        bus_write(ADDR_PAT, 32'h00000F0F, 1'b1, 16'h0F0F);
        chk("collide_cycle", cyc, k + 6);
        push(k + 9, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        bus_write(ADDR_MODE, 32'd0, 1'b1, 16'h0F0F);

        bus_write(ADDR_PERIOD, 32'd0, 1'b0, 16'h0);
        rd("period_zero_clamp", ADDR_PERIOD, 32'd1);

        // Reset during BOUNCE.
        bus_write(ADDR_PERIOD, 32'd2, 1'b0, 16'h0);
        bus_write(ADDR_PAT, 32'h00004000, 1'b1, 16'h4000);
        bus_write(ADDR_MODE, {30'd0, MODE_BOUNCE}, 1'b1, 16'h4000);
        k = cyc;
        push(k + 2, 16'h8000);
        push(k + 4, 16'h4000);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_queue", sb.size(), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_reset_led_we", {31'd0, led_we}, 32'd0);
        rst = 1'b0;
        push(cyc + 1, 16'h0000);
        repeat (20) @(posedge clk);
        #1;
        rd("post_reset_pat", ADDR_PAT, 32'd0);
        rd("post_reset_mode", ADDR_MODE, 32'd0);
        rd("post_reset_period", ADDR_PERIOD, TB_DIV);
        chk("final_queue_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
